cordic_vector: RTL and testbench
================================

// Module: cordic_vector
// PURPOSE
//  Iterative vectoring-mode CORDIC, the inverse of cordic_top: takes a Q16.16 (x,y) pair
//  (e.g. the cos_out/sin_out of cordic_top) and returns its angle in Q16.16 degrees (atan2)
//  and its gain-compensated magnitude. Same start/done handshake as cordic_top.
//  One micro-rotation per clock; used for phase/magnitude recovery and cordic_top round-trip checks.
// PARAMETERS
//  WIDTH  32  data width of x_in, y_in, theta_deg, mag_out (signed, Q(WIDTH-FRAC).FRAC)
//  FRAC   16  fractional bits
//  ITER   16  micro-rotations (1..WIDTH-FRAC); atan table holds ITER entries
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset (0 = reset)
//  start      in   1      request; sampled only in IDLE
//  x_in       in   WIDTH  signed Q16.16 x; captured on accepted start
//  y_in       in   WIDTH  signed Q16.16 y; captured on accepted start
//  theta_deg  out  WIDTH  signed Q16.16 degrees, range (-180,+180]
//  mag_out    out  WIDTH  signed Q16.16 sqrt(x^2+y^2), saturated to max positive
//  busy       out  1      high from accepted start until done
//  done       out  1      one-cycle pulse; results valid from this cycle on
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; theta_deg, mag_out, busy, done, all internal regs = 0.
//  FSM: IDLE -start-> PRE -> ITER (ITER cycles, i=0..ITER-1) -> POST -> IDLE.
//  - IDLE: start=1 at edge -> capture x_in/y_in, busy=1, go PRE. start=0: stay.
//  - PRE: quadrant fold. x<0: x=-x, y=-y, z=+180deg if y_in>=0 else -180deg. Else z=0.
//  - ITER step i: y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]; y<0: x-=y>>>i, y+=x>>>i, z-=ATAN[i]
//    (x,y updates use pre-step values). Arithmetic shifts.
//  - POST: theta_deg=z; mag_out=sat((x*K)>>>FRAC), K=0.6072529 in Q16.16 = 39797;
//    done=1, busy=0.
//  Latency: start sampled at edge N -> done high in the cycle after edge N+ITER+2;
//    next start is accepted at edge N+ITER+3 (back-to-back allowed).
//  Widths: internal x,y are WIDTH+2 bits (CORDIC gain 1.647 x sqrt2). z is WIDTH bits.
//    Product is 2*WIDTH+2 bits. Saturate mag_out to 2^(WIDTH-1)-1; mag_out is never negative.
//  ATAN[i] = round(atan(2^-i)*180/pi*2^FRAC): [0]=2949120, [1]=1740967, [2]=919879,
//    [3]=466945 ... constant table.
//  Exact cases, bypassing the iteration result but keeping the same latency:
//    - x=y=0 -> theta 0, mag 0.
//    - y=0, x<0 -> theta exactly +180deg (11796480).
//  Outputs hold their last result until the next POST; they never change mid-computation.
//  start while busy: ignored, no queuing. x_in/y_in changes after capture: ignored.
//  Reset mid-operation: abort immediately to the reset state; no done pulse.
//  done and busy are never high in the same cycle.
// TESTING (tolerance: theta +/-655 LSB = 0.01deg, mag +/-64 LSB, unless stated exact)
//  1. x=65536, y=0 -> theta 0, mag 65536; done exactly ITER+2 cycles after start.
//  2. x=y=65536 -> theta 2949120 (45deg), mag 92682.
//     x=65536, y=-65536 -> theta -2949120.
//  3. x=-65536, y=65536 -> theta 8847360 (135deg).
//     x=-65536, y=-65536 -> theta -8847360.
//     x=0, y=-65536 -> theta -5898240, mag 65536.
//  4. Corners: x=-65536, y=0 -> theta exactly 11796480. x=y=0 -> theta 0, mag 0 exactly.
//     x=y=0x7FFFFFFF -> mag saturates to 0x7FFFFFFF, theta 45deg.
//  5. Handshake:
//     - pulse start again during busy -> ignored, single done.
//     - start in the cycle after done -> accepted, correct second result.
//     - rst=0 mid-ITER -> all outputs 0, no done; the next start works.
//  6. Round trip: drive cordic_top with 0, +/-30, +/-45, +/-60, +/-90 deg, feed cos_out/sin_out
//     here -> theta within 0.02deg of input, mag within 1% of cordic_top output magnitude.

Source files
------------

// File: rtl/cordic_vector.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_vector
//  Purpose  : Iterative vectoring-mode CORDIC. Converts a signed fixed-point
//             (x,y) pair into its angle in degrees (atan2, range (-180,+180])
//             and its gain-compensated magnitude. One micro-rotation per clock.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_vector #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int ITER  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic signed [WIDTH-1:0] theta_deg,
  output logic signed [WIDTH-1:0] mag_out,
  output logic                    busy,
  output logic                    done
);

  // x,y carry two guard bits: CORDIC gain (~1.647) times sqrt(2) worst case.
  localparam int XW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 2;
  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

  // Table entries and fixed constants are written in 2^-16 units and rescaled
  // to the configured FRAC, so the same table serves other fixed-point formats.
  function automatic logic signed [WIDTH-1:0] q16_to_frac(input longint v);
    longint s;
    if (FRAC >= 16) s = v <<< (FRAC - 16);
    else            s = v >>> (16 - FRAC);
    return WIDTH'(s);
  endfunction

  // round(atan(2^-i) * 180/pi * 2^16)
  function automatic longint atan_q16(input int idx);
    case (idx)
      0:  return 64'sd2949120;
      1:  return 64'sd1740967;
      2:  return 64'sd919879;
      3:  return 64'sd466945;
      4:  return 64'sd234379;
      5:  return 64'sd117304;
      6:  return 64'sd58666;
      7:  return 64'sd29335;
      8:  return 64'sd14668;
      9:  return 64'sd7334;
      10: return 64'sd3667;
      11: return 64'sd1833;
      12: return 64'sd917;
      13: return 64'sd458;
      14: return 64'sd229;
      15: return 64'sd115;
      default: return 64'sd0;
    endcase
  endfunction

  localparam logic signed [WIDTH-1:0] c_180 = q16_to_frac(64'sd11796480);
  localparam logic signed [WIDTH-1:0] c_k   = q16_to_frac(64'sd39797);   // 1/gain
  localparam logic signed [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_POST = 2'd3
  } state_t;

  state_t                  r_state, w_next;
  logic signed [XW-1:0]    r_x, r_y;
  logic signed [WIDTH-1:0] r_z;
  logic [IW-1:0]           r_i;
  logic                    r_zero, r_negaxis;
  logic signed [WIDTH-1:0] r_theta, r_mag;
  logic                    r_busy, r_done;

  logic signed [XW-1:0]    w_xs, w_ys;
  logic signed [WIDTH-1:0] w_atan;
  logic signed [PW-1:0]    w_prod, w_scaled;
  logic signed [WIDTH-1:0] w_mag;

  assign w_xs   = r_x >>> r_i;
  assign w_ys   = r_y >>> r_i;
  assign w_atan = q16_to_frac(atan_q16(int'(r_i)));

  // Gain compensation; the folded x is never negative, but clamp anyway.
  assign w_prod   = PW'(r_x) * PW'(c_k);
  assign w_scaled = w_prod >>> FRAC;

  // Saturate the compensated magnitude into the output range [0, max].
  always_comb begin
    w_mag = '0;
    if (w_scaled < 0)                w_mag = '0;
    else if (w_scaled > PW'(c_max))  w_mag = c_max;
    else                             w_mag = w_scaled[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state sequencing: IDLE -> PRE -> ITER x ITER -> POST -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PRE;
      S_PRE:   w_next = S_ITER;
      S_ITER:  if (r_i == IW'(ITER - 1)) w_next = S_POST;
      S_POST:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, quadrant fold, micro-rotations, result registration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_i       <= '0;
      r_zero    <= 1'b0;
      r_negaxis <= 1'b0;
      r_theta   <= '0;
      r_mag     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= XW'(x_in);
            r_y    <= XW'(y_in);
            r_i    <= '0;
            r_busy <= 1'b1;
          end
        end
        S_PRE: begin
          // Exact cases are flagged now, before the fold changes x and y.
          r_zero    <= (r_x == '0) && (r_y == '0);
          r_negaxis <= (r_y == '0) && r_x[XW-1];
          if (r_x[XW-1]) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= r_y[XW-1] ? -c_180 : c_180;
          end else begin
            r_z <= '0;
          end
        end
        S_ITER: begin
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_i <= r_i + 1'b1;
        end
        S_POST: begin
          if (r_zero) begin
            r_theta <= '0;
            r_mag   <= '0;
          end else begin
            r_theta <= r_negaxis ? c_180 : r_z;
            r_mag   <= w_mag;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign theta_deg = r_theta;
  assign mag_out   = r_mag;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cordic_vector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_vector
//  Purpose  : Scoreboard bench for cordic_vector: directed vectors with
//             hand-computed angle/magnitude, latency and handshake checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_vector;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int ITER  = 16;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic signed [WIDTH-1:0] x_in, y_in;
  logic signed [WIDTH-1:0] theta_deg, mag_out;
  logic                    busy, done;

  cordic_vector #(.WIDTH(WIDTH), .FRAC(FRAC), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .theta_deg (theta_deg),
    .mag_out   (mag_out),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int     id;
    longint theta;
    longint mag;
    longint ttol;
    longint mtol;
    longint sedge;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint absdiff(input longint a, input longint b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic check(input string name, input int id, input longint act,
                       input longint req, input longint tol);
    checks++;
    if (absdiff(act, req) > tol) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d, expected %0d (tol %0d)", name, id, act, req, tol);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst && busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
    end
    if (rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: theta=%0d mag=%0d", theta_deg, mag_out);
      end else begin
        e = sb.pop_front();
        check("theta",   e.id, longint'(theta_deg), e.theta, e.ttol);
        check("mag",     e.id, longint'(mag_out),   e.mag,   e.mtol);
        check("latency", e.id, cyc - e.sedge,       longint'(ITER + 2), 0);
      end
    end
  end

  // Caller is positioned at a falling edge; start is sampled at the next rising edge.
  task automatic issue(input int id, input longint x, input longint y, input longint th,
                       input longint mg, input longint ttol, input longint mtol);
    exp_t e;
    #1;
    x_in  = WIDTH'(x);
    y_in  = WIDTH'(y);
    start = 1'b1;
    e.id = id; e.theta = th; e.mag = mg; e.ttol = ttol; e.mtol = mtol;
    e.sedge = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  localparam int NV = 10;
  longint vx [NV] = '{65536,  65536,    65536,  -65536,   -65536,  0,        -65536,   0, 32'h7FFFFFFF, 0};
  longint vy [NV] = '{0,      65536,   -65536,   65536,   -65536, -65536,    0,        0, 32'h7FFFFFFF, 65536};
  longint vt [NV] = '{0, 2949120, -2949120, 8847360, -8847360, -5898240, 11796480, 0, 2949120, 5898240};
  longint vm [NV] = '{65536, 92682, 92682, 92682, 92682, 65536, 65536, 0, 32'h7FFFFFFF, 65536};
  longint vtt[NV] = '{655, 655, 655, 655, 655, 655, 0, 0, 655, 655};
  longint vmt[NV] = '{64,  64,  64,  64,  64,  64,  64, 0, 0,   64};

  initial begin
    int n;
    rst   = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_theta", 0, longint'(theta_deg), 0, 0);
    check("rst_mag",   0, longint'(mag_out),   0, 0);
    check("rst_busy",  0, longint'(busy),      0, 0);
    check("rst_done",  0, longint'(done),      0, 0);
    #1 rst = 1'b1;

    // Directed vectors, one at a time.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      issue(k, vx[k], vy[k], vt[k], vm[k], vtt[k], vmt[k]);
      wait_idle();
    end

    // Start pulsed while busy and inputs changed after capture: both ignored.
    @(negedge clk);
    issue(20, 65536, 65536, 2949120, 92682, 655, 64);
    repeat (4) @(negedge clk);
    #1;
    x_in  = -65536;
    y_in  = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (ITER + 6) @(negedge clk);

    // Back-to-back: second start in the cycle right after done.
    @(negedge clk);
    issue(21, -65536, 65536, 8847360, 92682, 655, 64);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    issue(22, 65536, -65536, -2949120, 92682, 655, 64);
    wait_idle();

    // Reset mid-iteration: outputs clear, no done, next start works.
    @(negedge clk);
    issue(23, 65536, 0, 0, 65536, 655, 64);
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_theta", 23, longint'(theta_deg), 0, 0);
    check("midrst_mag",   23, longint'(mag_out),   0, 0);
    check("midrst_busy",  23, longint'(busy),      0, 0);
    check("midrst_done",  23, longint'(done),      0, 0);
    #1 rst = 1'b1;
    repeat (ITER + 6) @(negedge clk);
    issue(24, 0, 65536, 5898240, 65536, 655, 64);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
